ads127l01_fsync_tx: RTL and testbench

//  Synthesizable transmitter side of the ADS127L01 frame-sync master serial interface.

---
 rtl/ads127l01_fsync_tx.sv | 103 ++++++++++
 tb/tb_ads127l01_fsync_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ads127l01_fsync_tx.sv
// ads127l01_fsync_tx: ADS127L01 frame-sync master transmitter driving sck/dout/fsync from an AXI-Stream sample source.
// Optional CRC-8 trailer after the data bits when ADS127L01_TX_CRC_EN is defined.
module ads127l01_fsync_tx #(
    parameter int DW        = 24,
    parameter int SCK_DIV   = 2,
    parameter int FRAME_LEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    output logic          sck,
    output logic          dout,
    output logic          fsync,
    output logic          frame_done,
    output logic          underrun
);
    localparam int HW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
    localparam int KW = $clog2(FRAME_LEN);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [HW-1:0] half_cnt, nh;
    logic [KW-1:0] bit_k, nk;
    logic phase, np, hdone, last, load, n_run, hold_valid;
    logic [DW-1:0] hold, last_sent, word;
    logic [FRAME_LEN-1:0] fr;
`ifdef ADS127L01_TX_CRC_EN
    logic [7:0] crc, n_crc;
    if (FRAME_LEN < DW + 8) begin : g_len_err
        $error("FRAME_LEN must be at least DW+8 when the CRC trailer is enabled");
    end
    function automatic logic [7:0] crc8(input logic [DW-1:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = DW - 1; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction
`else
    if (FRAME_LEN < DW + 1) begin : g_len_err
        $error("FRAME_LEN must be at least DW+1");
    end
`endif
    assign s_axis_tready = !hold_valid | load;
    always_comb begin
        hdone = half_cnt == HW'(SCK_DIV - 1);
        last  = state == RUN && hdone && phase && bit_k == KW'(FRAME_LEN - 1);
        load  = en && (state == IDLE || last);
        n_run = load || (state == RUN && !last);
        nh    = (load || hdone) ? '0 : half_cnt + HW'(1);
        np    = load ? 1'b0 : (hdone ? !phase : phase);
        nk    = load ? '0 : ((hdone && phase) ? bit_k + KW'(1) : bit_k);
        // The word on the wire is always last_sent, except on the load cycle where it is replaced.
        word  = load ? (hold_valid ? hold : last_sent) : last_sent;
`ifdef ADS127L01_TX_CRC_EN
        n_crc = load ? crc8(word) : crc;
        fr    = FRAME_LEN'({word, n_crc}) << (FRAME_LEN - DW - 8);
`else
        fr    = FRAME_LEN'(word) << (FRAME_LEN - DW);
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            half_cnt   <= '0;
            phase      <= 1'b0;
            bit_k      <= '0;
            sck        <= 1'b0;
            dout       <= 1'b0;
            fsync      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            hold_valid <= 1'b0;
            hold       <= '0;
            last_sent  <= '0;
`ifdef ADS127L01_TX_CRC_EN
            crc        <= '0;
`endif
        end else begin
            state      <= n_run ? RUN : IDLE;
            half_cnt   <= nh;
            phase      <= np;
            bit_k      <= nk;
            // Outputs are registered from the next position so they line up with the counters.
            sck        <= n_run && np;
            fsync      <= n_run && nk == '0;
            dout       <= n_run && fr[KW'(FRAME_LEN - 1) - nk];
            frame_done <= n_run && nh == HW'(SCK_DIV - 1) && np && nk == KW'(FRAME_LEN - 1);
            underrun   <= load && !hold_valid;
            last_sent  <= word;
`ifdef ADS127L01_TX_CRC_EN
            crc        <= n_crc;
`endif
            if (s_axis_tvalid && s_axis_tready) begin
                hold       <= s_axis_tdata;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ads127l01_fsync_tx.sv
// tb_ads127l01_fsync_tx: frame-level model plus serial monitor checking ads127l01_fsync_tx every clk.
module tb_ads127l01_fsync_tx;
    localparam int DW = 24, SD = 2, FL = 32, FCLK = 2 * SD * FL;
    logic clk = 0, rst = 1, en = 0, s_axis_tvalid = 0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic s_axis_tready, sck, dout, fsync, frame_done, underrun;
    int n_chk = 0, n_fail = 0;

    ads127l01_fsync_tx #(.DW(DW), .SCK_DIV(SD), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .en(en), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .sck(sck),
        .dout(dout), .fsync(fsync), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] crc8(input logic [DW-1:0] d);
        logic [7:0] c = 8'hFF;
        for (int i = DW - 1; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    function automatic logic [7:0] trailer(input logic [DW-1:0] w);
`ifdef ADS127L01_TX_CRC_EN
        return crc8(w);
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [31:0] exp_frame(input logic [DW-1:0] w);
        return {w, trailer(w)};
    endfunction

    function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
        logic [31:0] f = exp_frame(w);
        return f[FL - 1 - k];
    endfunction

    // Frame-level model: tracks the word on the wire and the clk index within the frame.
    logic m_run = 0, m_hold_full = 0, m_ur = 0, started = 0;
    logic [DW-1:0] m_hold = '0, m_cur = '0;
    int m_c = 0;
    always @(posedge clk) begin
        logic ld, acc;
        if (rst) begin
            m_run = 0; m_c = 0; m_hold_full = 0; m_cur = '0; m_ur = 0;
        end else begin
            ld  = en && (!m_run || m_c == FCLK - 1);
            acc = s_axis_tvalid && (!m_hold_full || ld);
            if (ld) begin
                m_ur = !m_hold_full;
                m_cur = m_hold_full ? m_hold : m_cur;
                m_hold_full = 0; m_run = 1; m_c = 0;
            end else if (m_run) begin
                if (m_c == FCLK - 1) m_run = 0; else m_c++;
            end
            if (acc) begin m_hold = s_axis_tdata; m_hold_full = 1; end
        end
        started = 1;
    end

    int fd_cnt = 0, ur_cnt = 0, fs_cnt = 0, cyc = 0;
    int fd_time[$];
    always @(negedge clk) if (started) begin
        logic [5:0] e, a;
        int k, ph;
        k = m_c / (2 * SD);
        ph = m_c % (2 * SD);
        e[5:1] = m_run ? {ph >= SD, exp_bit(m_cur, k), m_c < 2 * SD, m_c == FCLK - 1, m_ur && m_c == 0} : 5'b0;
        e[0] = !m_hold_full || (en && (!m_run || m_c == FCLK - 1));
        a = {sck, dout, fsync, frame_done, underrun, s_axis_tready};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle %0d outputs{sck,dout,fsync,done,ur,rdy}: got %b want %b", cyc, a, e);
        end
        if (frame_done) begin fd_cnt++; fd_time.push_back(cyc); end
        if (underrun) ur_cnt++;
        if (fsync) fs_cnt++;
        cyc++;
    end

    // Receiver-side monitor: samples dout on sck rising, frames aligned by fsync.
    logic [31:0] rx[$];
    logic [31:0] rsh = '0;
    int rn = 0;
    always @(posedge sck) begin
        if (fsync) begin rsh = {31'b0, dout}; rn = 1; end
        else if (rn > 0) begin rsh = {rsh[30:0], dout}; rn++; end
        if (rn == FL) begin rx.push_back(rsh); rn = 0; end
    end

    function automatic logic [31:0] rx_back(input int i);
        return rx.size() > i ? rx[rx.size() - 1 - i] : 'x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        logic ok = 0;
        s_axis_tvalid = 1; s_axis_tdata = w;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin ok = 1; break; end
        end
        step(1);
        s_axis_tvalid = 0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_fd(input int target);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fd_cnt >= target) break;
        end
        if (fd_cnt < target) chk("frame_done_timeout", fd_cnt, target);
        step(1);
    endtask

    int fdi, urb, fsb;
    initial begin
        step(3);
        @(negedge clk);
        chk("reset_state", {28'b0, sck, dout, fsync, s_axis_tready}, 32'h1);
        step(1);
        rst = 0;
        step(2);
        // 1: single word
        push(24'hA5F00F); en = 1; step(1); en = 0;
        wait_fd(1); step(4);
        chk("t1_word", rx_back(0), {24'hA5F00F, trailer(24'hA5F00F)});
        chk("t1_fsync_clks", fs_cnt, 4);
        chk("t1_done_cnt", fd_cnt, 1);
        chk("t1_no_underrun", ur_cnt, 0);
        // 2: back-to-back frames
        fdi = fd_cnt;
        push(24'h000001); en = 1; push(24'h800000); push(24'h7FFFFF);
        wait_fd(fdi + 2); en = 0; wait_fd(fdi + 3); step(4);
        chk("t2_w0", rx_back(2), exp_frame(24'h000001));
        chk("t2_w1", rx_back(1), exp_frame(24'h800000));
        chk("t2_w2", rx_back(0), exp_frame(24'h7FFFFF));
        chk("t2_gap_a", fd_time[fdi + 1] - fd_time[fdi], FCLK);
        chk("t2_gap_b", fd_time[fdi + 2] - fd_time[fdi + 1], FCLK);
        chk("t2_no_underrun", ur_cnt, 0);
        // 3: underrun repeats the last word
        fdi = fd_cnt; urb = ur_cnt;
        push(24'h123456); en = 1; wait_fd(fdi + 1); en = 0; wait_fd(fdi + 2); step(4);
        chk("t3_first", rx_back(1), exp_frame(24'h123456));
        chk("t3_repeat", rx_back(0), exp_frame(24'h123456));
        chk("t3_underrun", ur_cnt, urb + 1);
        // 4: en dropped mid-frame, then restart
        fdi = fd_cnt;
        push(24'h0ABCDE); en = 1; step(1); step(41); en = 0;
        wait_fd(fdi + 1); step(20);
        fsb = fs_cnt; step(20);
        chk("t4_idle_quiet", fs_cnt, fsb);
        chk("t4_full_frame", rx_back(0), exp_frame(24'h0ABCDE));
        en = 1; step(1);
        @(negedge clk);
        chk("t4_restart", {30'b0, fsync, sck}, 32'h2);
        step(1); en = 0;
        wait_fd(fdi + 2); step(4);
        chk("t4_repeat", rx_back(0), exp_frame(24'h0ABCDE));
        // 5: reset mid-frame
        fdi = fd_cnt; urb = ur_cnt;
        push(24'h111111); en = 1; step(1); step(60);
        rst = 1; step(1);
        @(negedge clk);
        chk("t5_reset_outs", {27'b0, sck, dout, fsync, frame_done, s_axis_tready}, 32'h1);
        step(1); rst = 0; step(1); en = 0;
        wait_fd(fdi + 1); step(4);
        chk("t5_zero_word", rx_back(0), exp_frame(24'h000000));
        chk("t5_underrun", ur_cnt, urb + 1);
        // 6: trailer bits
        fdi = fd_cnt;
        push(24'h000000); en = 1; push(24'hA5F00F); wait_fd(fdi + 1); en = 0; wait_fd(fdi + 2); step(4);
        chk("t6_trailer0", {24'b0, rx_back(1) & 32'hFF}, {24'b0, trailer(24'h000000)});
        chk("t6_trailer1", {24'b0, rx_back(0) & 32'hFF}, {24'b0, trailer(24'hA5F00F)});
        chk("t6_data1", {8'b0, rx_back(0) >> 8}, 32'h00A5F00F);
        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
